rpn_alu_stage: RTL and testbench

RPN_ALU_STAGE -- requirements
Module: rpn_alu_stage

---
 rtl/rpn_alu_stage_if.sv | 42 ++++
 rtl/rpn_alu_stage.sv | 190 +++++++++++++++++++
 tb/tb_rpn_alu_stage.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rpn_alu_stage_if.sv
// rtl/rpn_alu_stage_if.sv - command and status bundle for the RPN ALU stage
//
// Purpose: carries the command handshake and the stack status outputs of
// rpn_alu_stage between the block and whatever drives it.
// Signals:
//   cmd_valid / cmd_ready   command handshake (accept when both are 1)
//   cmd_op    [2:0]         opcode
//   cmd_data  [WIDTH-1:0]   PUSH operand
//   done                    one-cycle completion pulse
//   top       [WIDTH-1:0]   top-of-stack value (0 when empty)
//   depth     [DW-1:0]      occupied entries, 0..DEPTH
//   err_underflow           last command lacked operands
//   err_overflow            last command exceeded capacity
//   arith_ovf               last arithmetic result wrapped
// Modports: master drives commands, slave is the ALU stage.
interface rpn_alu_stage_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int DW = $clog2(DEPTH) + 1;

  logic             cmd_valid;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_ready;
  logic             done;
  logic [WIDTH-1:0] top;
  logic [DW-1:0]    depth;
  logic             err_underflow;
  logic             err_overflow;
  logic             arith_ovf;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, done, top, depth, err_underflow, err_overflow, arith_ovf
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, done, top, depth, err_underflow, err_overflow, arith_ovf
  );
endinterface

// File: rtl/rpn_alu_stage.sv
// rtl/rpn_alu_stage.sv - stack-based RPN ALU with a four-state command FSM
//
// Purpose: accepts one command at a time, runs it through READ / EXEC / WRITE
// and commits the stack effect on the edge leaving WRITE.
// Ports:
//   CLOCK_50  in   rising-edge clock
//   reset     in   asynchronous active-high reset
//   bus       slave side of rpn_alu_stage_if (command handshake + status)
module rpn_alu_stage #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input logic            CLOCK_50,
  input logic            reset,
  rpn_alu_stage_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW = $clog2(DEPTH) + 1;

  localparam logic [2:0] OP_PUSH  = 3'd0;
  localparam logic [2:0] OP_ADD   = 3'd1;
  localparam logic [2:0] OP_SUB   = 3'd2;
  localparam logic [2:0] OP_MUL   = 3'd3;
  localparam logic [2:0] OP_DUP   = 3'd4;
  localparam logic [2:0] OP_SWAP  = 3'd5;
  localparam logic [2:0] OP_DROP  = 3'd6;
  localparam logic [2:0] OP_CLEAR = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WRITE} state_t;

  state_t            state, state_nxt;
  logic              cmd_ready_w, done_w, accept, commit;

  logic [WIDTH-1:0]  stack [DEPTH];
  logic [DW-1:0]     depth_q, depth_nxt;

  logic [2:0]        op_q;
  logic [WIDTH-1:0]  data_q, opa_q, opb_q, res_q;

  // Verdict of EXEC, held until the commit edge.
  logic              unf_q, ovf_q, aovf_q;
  logic              err_unf_q, err_ovf_q, arith_ovf_q;

  logic [WIDTH-1:0]  res_c;
  logic              unf_c, ovf_c, aovf_c, room_c;
  logic [DW-1:0]     need_c;
  logic [WIDTH:0]    sum_c;
  logic [2*WIDTH-1:0] prod_c;

  logic [AW-1:0]     idx_free, idx_top, idx_below;

  assign accept    = bus.cmd_valid && cmd_ready_w;
  assign commit    = (state == S_WRITE) && !unf_q && !ovf_q;
  // Truncation is safe: each index is only used when the depth guard holds.
  assign idx_free  = AW'(depth_q);
  assign idx_top   = AW'(depth_q - DW'(1));
  assign idx_below = AW'(depth_q - DW'(2));

  // FSM state register
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_READ;
      S_READ:  state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_WRITE;
      S_WRITE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs; ready is masked by reset so nothing is accepted while held.
  always_comb begin
    cmd_ready_w = (state == S_IDLE) && !reset;
    done_w      = (state == S_WRITE);
  end

  // Operand/room checks and arithmetic, evaluated in EXEC.
  always_comb begin
    need_c = '0;
    room_c = 1'b0;
    case (op_q)
      OP_PUSH:                        room_c = 1'b1;
      OP_DUP:                 begin need_c = DW'(1); room_c = 1'b1; end
      OP_DROP:                        need_c = DW'(1);
      OP_ADD, OP_SUB, OP_MUL, OP_SWAP: need_c = DW'(2);
      default: ;
    endcase
    unf_c  = (depth_q < need_c);
    ovf_c  = room_c && (depth_q == DW'(DEPTH));

    sum_c  = {1'b0, opa_q} + {1'b0, opb_q};
    prod_c = {{WIDTH{1'b0}}, opa_q} * {{WIDTH{1'b0}}, opb_q};

    res_c  = '0;
    aovf_c = 1'b0;
    case (op_q)
      OP_ADD: begin res_c = sum_c[WIDTH-1:0];  aovf_c = sum_c[WIDTH];              end
      OP_SUB: begin res_c = opa_q - opb_q;     aovf_c = (opa_q < opb_q);           end
      OP_MUL: begin res_c = prod_c[WIDTH-1:0]; aovf_c = |prod_c[2*WIDTH-1:WIDTH];  end
      default: ;
    endcase
    // A rejected command reports only its stack error, never a wrap.
    if (unf_c || ovf_c) aovf_c = 1'b0;
  end

  always_comb begin
    depth_nxt = depth_q;
    case (op_q)
      OP_PUSH, OP_DUP:                 depth_nxt = depth_q + DW'(1);
      OP_ADD, OP_SUB, OP_MUL, OP_DROP: depth_nxt = depth_q - DW'(1);
      OP_CLEAR:                        depth_nxt = '0;
      default: ;
    endcase
  end

  // Control/datapath registers
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      depth_q     <= '0;
      op_q        <= '0;
      data_q      <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      res_q       <= '0;
      unf_q       <= 1'b0;
      ovf_q       <= 1'b0;
      aovf_q      <= 1'b0;
      err_unf_q   <= 1'b0;
      err_ovf_q   <= 1'b0;
      arith_ovf_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          op_q        <= bus.cmd_op;
          data_q      <= bus.cmd_data;
          err_unf_q   <= 1'b0;
          err_ovf_q   <= 1'b0;
          arith_ovf_q <= 1'b0;
        end
        S_READ: begin
          opb_q <= (depth_q >= DW'(1)) ? stack[idx_top]   : '0;
          opa_q <= (depth_q >= DW'(2)) ? stack[idx_below] : '0;
        end
        S_EXEC: begin
          res_q  <= res_c;
          unf_q  <= unf_c;
          ovf_q  <= ovf_c;
          aovf_q <= aovf_c;
        end
        S_WRITE: begin
          err_unf_q   <= unf_q;
          err_ovf_q   <= ovf_q;
          arith_ovf_q <= aovf_q;
          if (commit) depth_q <= depth_nxt;
        end
        default: ;
      endcase
    end
  end

  // Stack storage; entries above depth are don't-care so no reset is needed.
  always_ff @(posedge CLOCK_50) begin
    if (commit) begin
      case (op_q)
        OP_PUSH:                stack[idx_free]  <= data_q;
        OP_DUP:                 stack[idx_free]  <= opb_q;
        OP_ADD, OP_SUB, OP_MUL: stack[idx_below] <= res_q;
        OP_SWAP: begin
          stack[idx_top]   <= opa_q;
          stack[idx_below] <= opb_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready     = cmd_ready_w;
  assign bus.done          = done_w;
  assign bus.top           = (depth_q != '0) ? stack[idx_top] : '0;
  assign bus.depth         = depth_q;
  assign bus.err_underflow = err_unf_q;
  assign bus.err_overflow  = err_ovf_q;
  assign bus.arith_ovf     = arith_ovf_q;
endmodule

// File: tb/tb_rpn_alu_stage.sv
// tb/tb_rpn_alu_stage.sv - self-checking bench for rpn_alu_stage
//
// Purpose: directed scenarios plus randomized command streams checked
// against a queue-based stack model.
// Ports: none (top-level bench); drives rpn_alu_stage through rpn_alu_stage_if.
module tb_rpn_alu_stage;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;

  localparam logic [2:0] OP_PUSH  = 3'd0;
  localparam logic [2:0] OP_ADD   = 3'd1;
  localparam logic [2:0] OP_SUB   = 3'd2;
  localparam logic [2:0] OP_MUL   = 3'd3;
  localparam logic [2:0] OP_DUP   = 3'd4;
  localparam logic [2:0] OP_SWAP  = 3'd5;
  localparam logic [2:0] OP_DROP  = 3'd6;
  localparam logic [2:0] OP_CLEAR = 3'd7;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;
  int   tests    = 0;
  int   fails    = 0;

  int   mstk[$];
  logic m_unf, m_ovf, m_aovf;

  rpn_alu_stage_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  rpn_alu_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int mtop();
    return (mstk.size() > 0) ? mstk[mstk.size()-1] : 0;
  endfunction

  // Stack semantics written directly from the opcode rules.
  task automatic model_apply(input logic [2:0] op, input logic [7:0] data);
    int n, a, b, r;
    n = mstk.size();
    m_unf = 1'b0; m_ovf = 1'b0; m_aovf = 1'b0;
    case (op)
      OP_PUSH: if (n == DEPTH) m_ovf = 1'b1; else mstk.push_back(int'(data));
      OP_ADD, OP_SUB, OP_MUL: begin
        if (n < 2) m_unf = 1'b1;
        else begin
          b = mstk.pop_back();
          a = mstk.pop_back();
          if (op == OP_ADD)      begin r = a + b; m_aovf = (r > 255); end
          else if (op == OP_SUB) begin r = a - b; m_aovf = (a < b);   end
          else                   begin r = a * b; m_aovf = (r > 255); end
          mstk.push_back(r & 255);
        end
      end
      OP_DUP: begin
        if (n < 1) m_unf = 1'b1;
        else if (n == DEPTH) m_ovf = 1'b1;
        else mstk.push_back(mstk[n-1]);
      end
      OP_SWAP: begin
        if (n < 2) m_unf = 1'b1;
        else begin
          a = mstk[n-1]; mstk[n-1] = mstk[n-2]; mstk[n-2] = a;
        end
      end
      OP_DROP:  if (n < 1) m_unf = 1'b1; else void'(mstk.pop_back());
      default:  mstk.delete();
    endcase
  endtask

  task automatic check_status(input string tag);
    check({tag, "_top"},   bus.top,           32'(mtop()));
    check({tag, "_depth"}, bus.depth,         32'(mstk.size()));
    check({tag, "_unf"},   bus.err_underflow, m_unf);
    check({tag, "_ovf"},   bus.err_overflow,  m_ovf);
    check({tag, "_aovf"},  bus.arith_ovf,     m_aovf);
  endtask

  // One full command: offer, accept, keep cmd_valid high with a different
  // command while busy, and check the done pulse lands in the third cycle.
  task automatic do_cmd(input logic [2:0] op, input logic [7:0] data);
    @(negedge CLOCK_50);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_data = data;
    check("ready_idle", bus.cmd_ready, 1'b1);
    @(posedge CLOCK_50);
    #1;
    bus.cmd_op   = ~op;
    bus.cmd_data = ~data;
    @(negedge CLOCK_50);
    check("done_c1", bus.done, 1'b0);
    check("ready_busy", bus.cmd_ready, 1'b0);
    check("flags_clr", {bus.err_underflow, bus.err_overflow, bus.arith_ovf}, 3'b000);
    @(negedge CLOCK_50);
    check("done_c2", bus.done, 1'b0);
    @(negedge CLOCK_50);
    check("done_c3", bus.done, 1'b1);
    bus.cmd_valid = 1'b0;
    model_apply(op, data);
    @(negedge CLOCK_50);
    check("done_after", bus.done, 1'b0);
    check_status("cmd");
  endtask

  task automatic pulse_reset();
    @(negedge CLOCK_50);
    bus.cmd_valid = 1'b0;
    reset = 1'b1;
    mstk.delete();
    m_unf = 1'b0; m_ovf = 1'b0; m_aovf = 1'b0;
    @(negedge CLOCK_50);
    reset = 1'b0;
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_data = '0;
    m_unf = 1'b0; m_ovf = 1'b0; m_aovf = 1'b0;

    // reset state
    repeat (2) @(negedge CLOCK_50);
    check("rst_ready", bus.cmd_ready, 1'b0);
    check("rst_done",  bus.done,      1'b0);
    check_status("rst");
    reset = 1'b0;
    @(posedge CLOCK_50); #1;
    check("rel_ready", bus.cmd_ready, 1'b1);

    // PUSH 3, PUSH 5, SUB
    do_cmd(OP_PUSH, 8'd3);
    do_cmd(OP_PUSH, 8'd5);
    do_cmd(OP_SUB, 8'd0);
    check("s_sub_top", bus.top, 8'hFE);
    check("s_sub_depth", bus.depth, 5'd1);
    check("s_sub_aovf", bus.arith_ovf, 1'b1);

    // underflow
    pulse_reset();
    do_cmd(OP_PUSH, 8'd7);
    do_cmd(OP_ADD, 8'd0);
    check("s_unf_flag", bus.err_underflow, 1'b1);
    check("s_unf_top", bus.top, 8'd7);
    check("s_unf_depth", bus.depth, 5'd1);

    // overflow at full depth
    pulse_reset();
    for (int i = 1; i <= 16; i++) do_cmd(OP_PUSH, 8'(i));
    do_cmd(OP_PUSH, 8'd99);
    check("s_ovf_flag", bus.err_overflow, 1'b1);
    check("s_ovf_depth", bus.depth, 5'd16);
    check("s_ovf_top", bus.top, 8'd16);
    do_cmd(OP_DUP, 8'd0);
    check("s_dup_full", bus.err_overflow, 1'b1);

    // MUL wrap then ADD without carry
    pulse_reset();
    do_cmd(OP_PUSH, 8'd20);
    do_cmd(OP_PUSH, 8'd13);
    do_cmd(OP_MUL, 8'd0);
    check("s_mul_top", bus.top, 8'h04);
    check("s_mul_aovf", bus.arith_ovf, 1'b1);
    do_cmd(OP_PUSH, 8'd200);
    do_cmd(OP_ADD, 8'd0);
    check("s_add_top", bus.top, 8'hCC);
    check("s_add_aovf", bus.arith_ovf, 1'b0);

    // SWAP / DUP / DROP / CLEAR
    pulse_reset();
    do_cmd(OP_PUSH, 8'd1);
    do_cmd(OP_PUSH, 8'd2);
    do_cmd(OP_SWAP, 8'd0);
    check("s_swap_top", bus.top, 8'd1);
    do_cmd(OP_DUP, 8'd0);
    check("s_dup_depth", bus.depth, 5'd3);
    check("s_dup_top", bus.top, 8'd1);
    do_cmd(OP_DROP, 8'd0);
    check("s_drop_depth", bus.depth, 5'd2);
    do_cmd(OP_CLEAR, 8'd0);
    check("s_clr_depth", bus.depth, 5'd0);
    check("s_clr_top", bus.top, 8'd0);

    // reset while an ADD sits in EXEC
    pulse_reset();
    do_cmd(OP_PUSH, 8'd3);
    do_cmd(OP_PUSH, 8'd4);
    @(negedge CLOCK_50);
    bus.cmd_valid = 1'b1; bus.cmd_op = OP_ADD; bus.cmd_data = '0;
    @(posedge CLOCK_50); #1;
    bus.cmd_op = OP_PUSH; bus.cmd_data = 8'h55;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    reset = 1'b1;
    mstk.delete();
    m_unf = 1'b0; m_ovf = 1'b0; m_aovf = 1'b0;
    #1;
    check("abort_ready", bus.cmd_ready, 1'b0);
    check("abort_done", bus.done, 1'b0);
    check_status("abort");
    for (int i = 0; i < 2; i++) begin
      @(negedge CLOCK_50);
      check("abort_hold_done", bus.done, 1'b0);
      check("abort_hold_depth", bus.depth, 5'd0);
    end
    bus.cmd_valid = 1'b0;
    reset = 1'b0;
    @(posedge CLOCK_50); #1;
    check("abort_rel_ready", bus.cmd_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLOCK_50);
      check("abort_post_done", bus.done, 1'b0);
      check_status("abort_post");
    end

    // randomized: balanced mix, then push-heavy to reach the full boundary
    pulse_reset();
    for (int i = 0; i < 200; i++) begin
      logic [2:0] op;
      op = ($urandom_range(0, 9) < 4) ? OP_PUSH : 3'($urandom_range(0, 7));
      do_cmd(op, 8'($urandom));
    end
    for (int i = 0; i < 80; i++) begin
      logic [2:0] op;
      op = ($urandom_range(0, 9) < 8) ? OP_PUSH : 3'($urandom_range(1, 6));
      do_cmd(op, 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
